cdru: RTL and testbench
=======================

Name: cdru

Overview:
- Conflict Detection Read Unit, one per memory bank. It is the read-side counterpart of the bank write arbiter.
- Arbitrates read requests from the three bank clients (i, d, c) onto the single bank read port.
- Tracks each accepted read through the fixed memory read latency.
- Steers returned read data back to the requester that issued it, as a registered data word plus a one-cycle valid pulse.

Parameters:
- BANKBITS, 5, bank-select address bits.
- WORDBITS, 9, word-within-bank address bits; address width a = BANKBITS+WORDBITS.
- DATABITS, 64, read data width.
- RDLAT, 2, memory read latency: cycles from m_en high to m_rdata valid (legal range 1..8).
- STARVE_LIM, 8, consecutive denied cycles before anti-starvation promotion (used only with the optional feature; legal range 1..255).

Ports:
- clk  input  1  clock; all state is updated on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- i_en  input  1  read request, client i.
- i_addr  input  a  read address, client i.
- i_grnt  output  1  request accepted this cycle, client i.
- i_rvalid  output  1  one-cycle pulse; i_rdata holds a new word.
- i_rdata  output  DATABITS  returned read data, client i.
- d_en, d_addr, d_grnt, d_rvalid, d_rdata: same as the i_* ports, for client d.
- c_en, c_addr, c_grnt, c_rvalid, c_rdata: same as the i_* ports, for client c.
- m_en  output  1  bank read enable.
- m_addr  output  a  bank read address.
- m_rdata  input  DATABITS  bank read data, valid RDLAT cycles after m_en.
- muxcode  output  2  code of the current grant: 0 = i, 1 = d, 2 = c, 3 = none.

Behaviour:
- Request path is combinational, with zero latency:
  - m_en = i_en | d_en | c_en.
  - m_addr = address of the winner; when nothing is granted m_addr = c_addr.
  - muxcode = code of the winner, or 3 when no request.
  - Exactly one grant is high whenever m_en is high; all grants are low otherwise.
- Default priority is fixed: i > d > c.
  - i_grnt = i_en.
  - d_grnt = d_en & ~i_en.
  - c_grnt = c_en & ~i_en & ~d_en.
- Tracking pipeline:
  - RDLAT-stage shift register; each stage holds {valid, code[1:0]}.
  - Stage 0 loads {m_en, muxcode} every cycle; there is no stall.
  - The stage RDLAT-1 output is the return tag, aligned with m_rdata.
- Return path is registered (+1 cycle):
  - When the return tag is valid with code k, the rising edge loads k_rdata <= m_rdata and sets k_rvalid = 1 for exactly one cycle.
  - The other rdata registers hold their value; the other rvalid outputs are 0.
- Latency:
  - A grant at cycle t gives k_rvalid high at cycle t+RDLAT+1.
  - Back-to-back grants on consecutive cycles give back-to-back rvalid pulses, in grant order, at full throughput.
- Reset (asynchronous, rst_n low):
  - All pipeline valid bits clear to 0.
  - All rvalid outputs clear to 0.
  - All rdata registers clear to 0.
  - Starvation counters clear to 0.
  - Grants and m_en remain combinational functions of the inputs, even while rst_n is low.
- Reset asserted mid-flight: every in-flight read is discarded and no rvalid pulse is produced for it after rst_n rises. The memory may still return data; that data is ignored.
- Code 3 in a valid stage is unreachable. If it occurs it is treated as not valid and produces no rvalid.
- Requests are not queued. A denied client must hold en/addr and retry; en may drop at any time without penalty.

Optional Feature:
- Macro: CDRU_ANTISTARVE_EN.
- When defined, each of clients d and c has an 8-bit saturating counter:
  - Increments on a cycle with en=1 and grnt=0.
  - Clears on grant or when en=0.
- Promotion:
  - When a counter is >= STARVE_LIM, that client outranks i for one grant.
  - If d and c are both promoted, d wins that cycle and c stays promoted.
  - A promoted client's counter clears when it is granted.
- i can therefore be denied. Only while the macro is defined, i_grnt = i_en & ~(promoted winner).
- When undefined, there are no counters and priority is strictly fixed i > d > c.

Test Plan:
- Single read: RDLAT=2, d_en=1, d_addr=0x0123 for one cycle at t=0, m_rdata=0xAA at t=2 -> d_grnt=1, m_addr=0x0123, muxcode=1 at t=0; d_rvalid=1 and d_rdata=0xAA at t=3 only; i_rvalid and c_rvalid stay 0.
- Three-way conflict: i, d, c all asserted at t=0 with addresses 1, 2, 3 -> only i_grnt, m_addr=1, muxcode=0. Drop i_en at t=1 -> d granted, addr 2. Drop d_en at t=2 -> c granted, addr 3. rvalid pulses i, d, c at t=3, 4, 5 with matching data.
- Streaming: c_en=1 for 10 cycles, addr incrementing 0..9, memory returns data = addr -> c_rvalid high for 10 consecutive cycles starting at t=3, c_rdata = 0..9 in order.
- Reset mid-flight: grant i at t=0, pull rst_n low at t=1 for one cycle -> i_rvalid never pulses, i_rdata=0; a new read issued after reset returns normally.
- Idle: all en=0 -> m_en=0, muxcode=3, all grants 0, no rvalid pulses.
- With CDRU_ANTISTARVE_EN, STARVE_LIM=8: i_en and c_en held high for 12 cycles -> c denied for cycles 0..7, c_grnt=1 and i_grnt=0 at cycle 8, i regains the grant at cycle 9.

Source files
------------

// File: rtl/cdru_if.sv
// Bank read-side bus: three client request/return channels plus the bank read port.
// slave is the cdru side; master is the client/memory side.
interface cdru_if #(
  parameter int BANKBITS = 5,
  parameter int WORDBITS = 9,
  parameter int DATABITS = 64
);
  localparam int A = BANKBITS + WORDBITS;

  logic                i_en, d_en, c_en;
  logic [A-1:0]        i_addr, d_addr, c_addr;
  logic                i_grnt, d_grnt, c_grnt;
  logic                i_rvalid, d_rvalid, c_rvalid;
  logic [DATABITS-1:0] i_rdata, d_rdata, c_rdata;
  logic                m_en;
  logic [A-1:0]        m_addr;
  logic [DATABITS-1:0] m_rdata;
  logic [1:0]          muxcode;

  modport slave (
    input  i_en, i_addr, d_en, d_addr, c_en, c_addr, m_rdata,
    output i_grnt, d_grnt, c_grnt, i_rvalid, d_rvalid, c_rvalid,
           i_rdata, d_rdata, c_rdata, m_en, m_addr, muxcode
  );

  modport master (
    output i_en, i_addr, d_en, d_addr, c_en, c_addr, m_rdata,
    input  i_grnt, d_grnt, c_grnt, i_rvalid, d_rvalid, c_rvalid,
           i_rdata, d_rdata, c_rdata, m_en, m_addr, muxcode
  );
endinterface

// File: rtl/cdru.sv
// Conflict Detection Read Unit: arbitrates i/d/c reads onto one bank port and steers data back.
// Optional anti-starvation promotion of d/c over i is enabled by defining CDRU_ANTISTARVE_EN.

// Per-client return register: captures bank data and pulses rvalid for one cycle.
module cdru_ret #(
  parameter int DATABITS = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                hit,
  input  logic [DATABITS-1:0] rdata_in,
  output logic                rvalid,
  output logic [DATABITS-1:0] rdata
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid <= 1'b0;
      rdata  <= '0;
    end else begin
      rvalid <= hit;
      if (hit) rdata <= rdata_in;
    end
  end
endmodule

module cdru #(
  parameter int BANKBITS   = 5,
  parameter int WORDBITS   = 9,
  parameter int DATABITS   = 64,
  parameter int RDLAT      = 2,
  parameter int STARVE_LIM = 8
) (
  input  logic  clk,
  input  logic  rst_n,
  cdru_if.slave bus
);
  localparam int A = BANKBITS + WORDBITS;
  localparam int NCLI = 3;

  if ((RDLAT < 1) || (RDLAT > 8) || (STARVE_LIM < 1) || (STARVE_LIM > 255)) begin : g_bad_param
    $error("cdru: RDLAT or STARVE_LIM out of range");
  end

  logic       req;
  logic [1:0] code;
  logic [A-1:0] maddr;

  assign req = bus.i_en | bus.d_en | bus.c_en;

`ifdef CDRU_ANTISTARVE_EN
  logic [7:0] d_cnt, c_cnt;
  logic       d_promo, c_promo;

  assign d_promo = bus.d_en && (d_cnt >= 8'(STARVE_LIM));
  assign c_promo = bus.c_en && (c_cnt >= 8'(STARVE_LIM));

  // Counters measure consecutive denied cycles; dropping en forfeits the credit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_cnt <= '0;
      c_cnt <= '0;
    end else begin
      if (!bus.d_en || code == 2'd1) d_cnt <= '0;
      else if (d_cnt != 8'hFF)       d_cnt <= d_cnt + 8'd1;
      if (!bus.c_en || code == 2'd2) c_cnt <= '0;
      else if (c_cnt != 8'hFF)       c_cnt <= c_cnt + 8'd1;
    end
  end
`endif

  always_comb begin
    code = 2'd3;
`ifdef CDRU_ANTISTARVE_EN
    if      (d_promo)  code = 2'd1;
    else if (c_promo)  code = 2'd2;
    else
`endif
    if      (bus.i_en) code = 2'd0;
    else if (bus.d_en) code = 2'd1;
    else if (bus.c_en) code = 2'd2;
  end

  always_comb begin
    case (code)
      2'd0:    maddr = bus.i_addr;
      2'd1:    maddr = bus.d_addr;
      default: maddr = bus.c_addr;
    endcase
  end

  assign bus.i_grnt  = (code == 2'd0);
  assign bus.d_grnt  = (code == 2'd1);
  assign bus.c_grnt  = (code == 2'd2);
  assign bus.m_en    = req;
  assign bus.m_addr  = maddr;
  assign bus.muxcode = code;

  // Tag pipeline tracks each read through the bank latency; no stall.
  logic [RDLAT-1:0]      vld_pipe;
  logic [RDLAT-1:0][1:0] code_pipe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe  <= '0;
      code_pipe <= '1;
    end else begin
      vld_pipe[0]  <= req;
      code_pipe[0] <= code;
      for (int s = 1; s < RDLAT; s++) begin
        vld_pipe[s]  <= vld_pipe[s-1];
        code_pipe[s] <= code_pipe[s-1];
      end
    end
  end

  logic [NCLI-1:0]               hit;
  logic [NCLI-1:0]               rvalid_v;
  logic [NCLI-1:0][DATABITS-1:0] rdata_v;

  // A stray code 3 never matches a client, so it is dropped silently.
  for (genvar k = 0; k < NCLI; k++) begin : g_ret
    assign hit[k] = vld_pipe[RDLAT-1] && (code_pipe[RDLAT-1] == 2'(k));
    cdru_ret #(.DATABITS(DATABITS)) u_ret (
      .clk      (clk),
      .rst_n    (rst_n),
      .hit      (hit[k]),
      .rdata_in (bus.m_rdata),
      .rvalid   (rvalid_v[k]),
      .rdata    (rdata_v[k])
    );
  end

  assign bus.i_rvalid = rvalid_v[0];
  assign bus.d_rvalid = rvalid_v[1];
  assign bus.c_rvalid = rvalid_v[2];
  assign bus.i_rdata  = rdata_v[0];
  assign bus.d_rdata  = rdata_v[1];
  assign bus.c_rdata  = rdata_v[2];
endmodule

// File: tb/tb_cdru.sv
// Directed bench for cdru: table of combinational arbitration vectors plus multi-cycle sequences.
module tb_cdru;
  localparam int A = 14;
  localparam int RDLAT = 2;
  localparam logic [A-1:0] IA = 14'h0011, DA = 14'h0222, CA = 14'h3333;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cdru_if #(.BANKBITS(5), .WORDBITS(9), .DATABITS(64)) bus ();

  cdru #(.BANKBITS(5), .WORDBITS(9), .DATABITS(64), .RDLAT(RDLAT), .STARVE_LIM(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic logic [63:0] mem_data(input logic [A-1:0] a);
    return {16'hD00D, 34'h0, a};
  endfunction

  // Bank model: data for the address presented with m_en appears RDLAT cycles later.
  logic [A-1:0] rq [RDLAT];
  always @(posedge clk) begin
    rq[0] <= bus.m_addr;
    for (int s = 1; s < RDLAT; s++) rq[s] <= rq[s-1];
  end
  assign bus.m_rdata = mem_data(rq[RDLAT-1]);

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] rv();
    return {bus.i_rvalid, bus.d_rvalid, bus.c_rvalid};
  endfunction

  function automatic logic [2:0] gr();
    return {bus.i_grnt, bus.d_grnt, bus.c_grnt};
  endfunction

  task automatic idle();
    bus.i_en = 0; bus.d_en = 0; bus.c_en = 0;
  endtask

  typedef struct {
    logic [2:0]   en;     // {i,d,c}
    logic [2:0]   grnt;   // {i,d,c}
    logic [1:0]   mux;
    logic [A-1:0] maddr;
  } vec_t;
  vec_t vecs[8];

  initial begin
    vecs[0] = '{3'b000, 3'b000, 2'd3, CA};
    vecs[1] = '{3'b001, 3'b001, 2'd2, CA};
    vecs[2] = '{3'b010, 3'b010, 2'd1, DA};
    vecs[3] = '{3'b011, 3'b010, 2'd1, DA};
    vecs[4] = '{3'b100, 3'b100, 2'd0, IA};
    vecs[5] = '{3'b101, 3'b100, 2'd0, IA};
    vecs[6] = '{3'b110, 3'b100, 2'd0, IA};
    vecs[7] = '{3'b111, 3'b100, 2'd0, IA};

    rst_n = 1'b0;
    idle();
    bus.i_addr = '0; bus.d_addr = '0; bus.c_addr = '0;
    #12;
    chk("rst_rvalid", 64'(rv()), 64'd0);
    chk("rst_i_rdata", bus.i_rdata, 64'd0);
    chk("rst_d_rdata", bus.d_rdata, 64'd0);
    chk("rst_c_rdata", bus.c_rdata, 64'd0);
    chk("rst_muxcode", 64'(bus.muxcode), 64'd3);
    bus.d_en = 1;
    #1;
    chk("rst_comb_grant", 64'(gr()), 64'b010);
    idle();
    nxt();
    rst_n = 1'b1;

    // Combinational request path
    for (int v = 0; v < 8; v++) begin
      {bus.i_en, bus.d_en, bus.c_en} = vecs[v].en;
      bus.i_addr = IA; bus.d_addr = DA; bus.c_addr = CA;
      @(negedge clk);
      chk($sformatf("vec%0d_grnt", v), 64'(gr()), 64'(vecs[v].grnt));
      chk($sformatf("vec%0d_men", v), 64'(bus.m_en), 64'(|vecs[v].en));
      chk($sformatf("vec%0d_mux", v), 64'(bus.muxcode), 64'(vecs[v].mux));
      chk($sformatf("vec%0d_maddr", v), 64'(bus.m_addr), 64'(vecs[v].maddr));
      nxt();
    end
    idle();
    repeat (RDLAT + 3) nxt();

    // Single read from d
    for (int t = 0; t < 6; t++) begin
      bus.d_en = (t == 0); bus.d_addr = 14'h0123;
      @(negedge clk);
      if (t == 0) begin
        chk("single_grnt", 64'(gr()), 64'b010);
        chk("single_maddr", 64'(bus.m_addr), 64'h0123);
        chk("single_mux", 64'(bus.muxcode), 64'd1);
      end
      chk($sformatf("single_rv_t%0d", t), 64'(rv()), (t == 3) ? 64'b010 : 64'd0);
      if (t == 3) chk("single_rdata", bus.d_rdata, mem_data(14'h0123));
      nxt();
    end

    // Three-way conflict, requesters dropping out one per cycle
    for (int t = 0; t < 7; t++) begin
      bus.i_en = (t < 1); bus.d_en = (t < 2); bus.c_en = (t < 3);
      bus.i_addr = 14'd1; bus.d_addr = 14'd2; bus.c_addr = 14'd3;
      @(negedge clk);
      if (t < 3) begin
        chk($sformatf("conf_grnt_t%0d", t), 64'(gr()), 64'(3'b100 >> t));
        chk($sformatf("conf_maddr_t%0d", t), 64'(bus.m_addr), 64'(t + 1));
        chk($sformatf("conf_mux_t%0d", t), 64'(bus.muxcode), 64'(t));
      end
      chk($sformatf("conf_rv_t%0d", t), 64'(rv()),
          (t >= 3 && t <= 5) ? 64'(3'b100 >> (t - 3)) : 64'd0);
      if (t == 3) chk("conf_i_rdata", bus.i_rdata, mem_data(14'd1));
      if (t == 4) chk("conf_d_rdata", bus.d_rdata, mem_data(14'd2));
      if (t == 5) chk("conf_c_rdata", bus.c_rdata, mem_data(14'd3));
      nxt();
    end

    // Streaming from c at full throughput
    for (int t = 0; t < 14; t++) begin
      bus.c_en = (t < 10); bus.c_addr = 14'(t);
      @(negedge clk);
      chk($sformatf("strm_grnt_t%0d", t), 64'(bus.c_grnt), 64'(t < 10));
      chk($sformatf("strm_rv_t%0d", t), 64'(rv()), (t >= 3 && t <= 12) ? 64'b001 : 64'd0);
      if (t >= 3 && t <= 12) chk($sformatf("strm_rdata_t%0d", t), bus.c_rdata, mem_data(14'(t - 3)));
      nxt();
    end
    idle();

    // Reset mid-flight; a d read issued during reset must also vanish
    for (int t = 0; t < 12; t++) begin
      bus.i_en = (t == 0 || t == 7); bus.i_addr = (t == 0) ? 14'd5 : 14'd7;
      bus.d_en = (t == 1); bus.d_addr = 14'd9;
      rst_n = (t != 1);
      @(negedge clk);
      if (t == 1) chk("rstm_comb_grnt", 64'(gr()), 64'b010);
      if (t >= 1 && t <= 9) chk($sformatf("rstm_i_rdata_t%0d", t), bus.i_rdata, 64'd0);
      chk($sformatf("rstm_rv_t%0d", t), 64'(rv()), (t == 10) ? 64'b100 : 64'd0);
      if (t == 10) chk("rstm_new_rdata", bus.i_rdata, mem_data(14'd7));
      nxt();
    end
    idle();

    // i and c held together: c starves unless promotion is built in
    for (int t = 0; t < 12; t++) begin
      bus.i_en = 1; bus.c_en = 1;
      bus.i_addr = 14'(t); bus.c_addr = 14'(12'h100 + t);
      @(negedge clk);
`ifdef CDRU_ANTISTARVE_EN
      chk($sformatf("starve_grnt_t%0d", t), 64'(gr()), (t == 8) ? 64'b001 : 64'b100);
`else
      chk($sformatf("starve_grnt_t%0d", t), 64'(gr()), 64'b100);
`endif
      nxt();
    end
    idle();
    repeat (RDLAT + 2) nxt();

    // Idle
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      chk($sformatf("idle_men_t%0d", t), 64'(bus.m_en), 64'd0);
      chk($sformatf("idle_mux_t%0d", t), 64'(bus.muxcode), 64'd3);
      chk($sformatf("idle_grnt_t%0d", t), 64'(gr()), 64'd0);
      chk($sformatf("idle_rv_t%0d", t), 64'(rv()), 64'd0);
      nxt();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
